// File: rtl/edge_pkg.sv
// Shared widths and types for the edge-capture event path.
// Default sizing matches the 32-bit sticky edge-capture stage.
package edge_pkg;

  localparam int EDGE_W     = 32;
  localparam int EDGE_IDX_W = $clog2(EDGE_W);

  typedef logic [EDGE_W-1:0]     edge_vec_t;
  typedef logic [EDGE_IDX_W-1:0] edge_idx_t;

endpackage

// File: rtl/edge_event_serializer_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// The request vector is doubled so the wrap becomes a plain priority scan.
module rr_pick
  import edge_pkg::*;
#(
  parameter int WIDTH = EDGE_W,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  localparam int DW = 2 * WIDTH;

  logic [DW-1:0] req2;
  logic [DW-1:0] keep;
  logic [DW-1:0] masked;

  assign req2   = {req, req};
  assign keep   = ~((DW'(1) << ptr) - DW'(1));
  assign masked = req2 & keep;

  // Lowest set bit of the masked double vector, folded back mod WIDTH.
  always_comb begin
    sel = '0;
    any = |req;
    for (int i = DW - 1; i >= 0; i--) begin
      if (masked[i]) sel = IDX_W'(i);
    end
  end

endmodule

// File: rtl/edge_event_serializer.sv
// Serializes newly risen capture bits into indexed event beats.
// Tracks lost events when a bit re-fires while still pending.
module edge_event_serializer
  import edge_pkg::*;
#(
  parameter int WIDTH = EDGE_W,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cap,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             overflow,
  output logic             busy
);

  logic [WIDTH-1:0] cap_q,  cap_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] ptr_q,  ptr_d;
  logic [IDX_W-1:0] idx_q,  idx_d;
  logic             vld_q,  vld_d;
  logic             ovf_q,  ovf_d;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] grant;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic             load;

  rr_pick #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (pend_q),
    .ptr (ptr_q),
    .sel (sel),
    .any (any)
  );

  assign rise = cap & ~cap_q;
  assign load = !vld_q || out_ready;

  // Output register load, pointer advance and pending/overflow update.
  always_comb begin
    cap_d = cap;
    vld_d = vld_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    grant = '0;
    if (load) begin
      vld_d = any;
      if (any) begin
        idx_d = sel;
        ptr_d = sel + IDX_W'(1);
        grant = WIDTH'(1) << sel;
      end
    end
    pend_d = (pend_q & ~grant) | rise;
    ovf_d  = ovf_q | (|(rise & pend_q & ~grant));
  end

  // State registers; reset wins over every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q  <= '0;
      pend_q <= '0;
      ptr_q  <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = vld_q;
  assign out_idx   = idx_q;
  assign overflow  = ovf_q;
  assign busy      = (|pend_q) || vld_q;

endmodule
